// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side inputs, forwarding sources and EX-side results.
interface id_ex_if #(
  parameter int W = 32
);
  logic [4:0]   id_rs, id_rt, id_rd;
  logic [W-1:0] id_dr1, id_dr2, id_imm;
  logic         id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst;
  logic [2:0]   id_aluop;
  logic         flush;
  logic         exmem_regwrite;
  logic [4:0]   exmem_aw;
  logic [W-1:0] exmem_alu;
  logic         memwb_regwrite;
  logic [4:0]   memwb_aw;
  logic [W-1:0] memwb_data;

  logic         stall;
  logic         ex_valid;
  logic [4:0]   ex_rs, ex_rt, ex_wreg;
  logic [W-1:0] ex_imm;
  logic         ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc;
  logic [2:0]   ex_aluop;
  logic [1:0]   fwd_a, fwd_b;
  logic [W-1:0] ex_opa, ex_opb, ex_store_data;

  modport master (
    output id_rs, id_rt, id_rd, id_dr1, id_dr2, id_imm,
           id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst, id_aluop,
           flush, exmem_regwrite, exmem_aw, exmem_alu, memwb_regwrite, memwb_aw, memwb_data,
    input  stall, ex_valid, ex_rs, ex_rt, ex_wreg, ex_imm,
           ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_aluop,
           fwd_a, fwd_b, ex_opa, ex_opb, ex_store_data
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_dr1, id_dr2, id_imm,
           id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst, id_aluop,
           flush, exmem_regwrite, exmem_aw, exmem_alu, memwb_regwrite, memwb_aw, memwb_data,
    output stall, ex_valid, ex_rs, ex_rt, ex_wreg, ex_imm,
           ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_aluop,
           fwd_a, fwd_b, ex_opa, ex_opb, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
module id_ex_stage #(
  parameter int W = 32
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic         valid;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   wreg;
    logic [W-1:0] imm;
    logic [W-1:0] dr1;
    logic [W-1:0] dr2;
    logic         regwrite;
    logic         memtoreg;
    logic         memread;
    logic         memwrite;
    logic         alusrc;
    logic [2:0]   aluop;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic hz;

  assign hz = ex_q.memread & ex_q.valid & (ex_q.rt != '0) &
              ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));
  assign bus.stall = hz & ~bus.flush;

  // Flush and load-use both load an all-zero bubble, so their priority collapses.
  always_comb begin
    ex_d = '0;
    if (!(bus.flush || hz)) begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.wreg     = bus.id_regdst ? bus.id_rd : bus.id_rt;
      ex_d.imm      = bus.id_imm;
      ex_d.dr1      = bus.id_dr1;
      ex_d.dr2      = bus.id_dr2;
      ex_d.regwrite = bus.id_regwrite;
      ex_d.memtoreg = bus.id_memtoreg;
      ex_d.memread  = bus.id_memread;
      ex_d.memwrite = bus.id_memwrite;
      ex_d.alusrc   = bus.id_alusrc;
      ex_d.aluop    = bus.id_aluop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  logic [1:0]   fwd_a, fwd_b;
  logic [W-1:0] opa, opb;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (bus.exmem_regwrite && bus.exmem_aw != '0 && bus.exmem_aw == ex_q.rs)      fwd_a = 2'b10;
    else if (bus.memwb_regwrite && bus.memwb_aw != '0 && bus.memwb_aw == ex_q.rs) fwd_a = 2'b01;
    if (bus.exmem_regwrite && bus.exmem_aw != '0 && bus.exmem_aw == ex_q.rt)      fwd_b = 2'b10;
    else if (bus.memwb_regwrite && bus.memwb_aw != '0 && bus.memwb_aw == ex_q.rt) fwd_b = 2'b01;
  end

  always_comb begin
    unique case (fwd_a)
      2'b10:   opa = bus.exmem_alu;
      2'b01:   opa = bus.memwb_data;
      default: opa = ex_q.dr1;
    endcase
    unique case (fwd_b)
      2'b10:   opb = bus.exmem_alu;
      2'b01:   opb = bus.memwb_data;
      default: opb = ex_q.dr2;
    endcase
  end

  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.ex_opa        = opa;
  assign bus.ex_opb        = opb;
  assign bus.ex_store_data = opb;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_wreg       = ex_q.wreg;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memtoreg   = ex_q.memtoreg;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_alusrc     = ex_q.alusrc;
  assign bus.ex_aluop      = ex_q.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  id_ex_if #(.W(32)) bus ();

  id_ex_stage #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the EX stage should be holding, as seen by the rest of the pipeline.
  typedef struct {
    bit        valid;
    bit [4:0]  rs, rt, wreg;
    bit [31:0] imm, dr1, dr2;
    bit        regwrite, memtoreg, memread, memwrite, alusrc;
    bit [2:0]  aluop;
  } ex_model_t;

  ex_model_t m;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_model_t empty_ex();
    ex_model_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic bit load_use(input ex_model_t e);
    return e.valid && e.memread && e.rt != 0 && (e.rt == bus.id_rs || e.rt == bus.id_rt);
  endfunction

  function automatic bit [1:0] exp_sel(input bit [4:0] r);
    if (r == 0) return 2'b00;
    if (bus.exmem_regwrite && bus.exmem_aw == r) return 2'b10;
    if (bus.memwb_regwrite && bus.memwb_aw == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit [31:0] exp_val(input bit [4:0] r, input bit [31:0] regval);
    bit [1:0] s;
    s = exp_sel(r);
    if (s == 2'b10) return bus.exmem_alu;
    if (s == 2'b01) return bus.memwb_data;
    return regval;
  endfunction

  function automatic ex_model_t model_next(input ex_model_t cur);
    ex_model_t n;
    if (bus.flush || load_use(cur)) return empty_ex();
    n.valid    = 1;
    n.rs       = bus.id_rs;
    n.rt       = bus.id_rt;
    n.wreg     = bus.id_regdst ? bus.id_rd : bus.id_rt;
    n.imm      = bus.id_imm;
    n.dr1      = bus.id_dr1;
    n.dr2      = bus.id_dr2;
    n.regwrite = bus.id_regwrite;
    n.memtoreg = bus.id_memtoreg;
    n.memread  = bus.id_memread;
    n.memwrite = bus.id_memwrite;
    n.alusrc   = bus.id_alusrc;
    n.aluop    = bus.id_aluop;
    return n;
  endfunction

  task automatic check_all();
    check("stall",    bus.stall,       32'(load_use(m) && !bus.flush));
    check("ex_valid", bus.ex_valid,    32'(m.valid));
    check("ex_rs",    bus.ex_rs,       32'(m.rs));
    check("ex_rt",    bus.ex_rt,       32'(m.rt));
    check("ex_wreg",  bus.ex_wreg,     32'(m.wreg));
    check("ex_imm",   bus.ex_imm,      m.imm);
    check("ex_ctrl",  {bus.ex_regwrite, bus.ex_memtoreg, bus.ex_memread, bus.ex_memwrite, bus.ex_alusrc, bus.ex_aluop},
                      32'({m.regwrite, m.memtoreg, m.memread, m.memwrite, m.alusrc, m.aluop}));
    check("fwd_a",    bus.fwd_a,       32'(exp_sel(m.rs)));
    check("fwd_b",    bus.fwd_b,       32'(exp_sel(m.rt)));
    check("ex_opa",   bus.ex_opa,      exp_val(m.rs, m.dr1));
    check("ex_opb",   bus.ex_opb,      exp_val(m.rt, m.dr2));
    check("ex_store", bus.ex_store_data, exp_val(m.rt, m.dr2));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m = empty_ex();
    else     m = model_next(m);
    #1;
  endtask

  task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] dr1, input bit [31:0] dr2,
                        input bit regdst, input bit regwrite, input bit memread);
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_dr1 = dr1; bus.id_dr2 = dr2; bus.id_imm = dr1 ^ 32'h5A5A_0000;
    bus.id_regdst = regdst; bus.id_regwrite = regwrite; bus.id_memread = memread;
    bus.id_memtoreg = memread; bus.id_memwrite = 1'b0; bus.id_alusrc = memread;
    bus.id_aluop = 3'd2;
  endtask

  task automatic quiet_wb();
    bus.exmem_regwrite = 0; bus.exmem_aw = 0; bus.exmem_alu = 0;
    bus.memwb_regwrite = 0; bus.memwb_aw = 0; bus.memwb_data = 0;
    bus.flush = 0;
  endtask

  task automatic rand_id();
    bus.id_rs = 5'($urandom_range(0, 3));
    bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rd = 5'($urandom_range(0, 3));
    bus.id_dr1 = $urandom; bus.id_dr2 = $urandom; bus.id_imm = $urandom;
    bus.id_regwrite = 1'($urandom); bus.id_memtoreg = 1'($urandom);
    bus.id_memread = ($urandom_range(0, 2) == 0); bus.id_memwrite = 1'($urandom);
    bus.id_alusrc = 1'($urandom); bus.id_regdst = 1'($urandom);
    bus.id_aluop = 3'($urandom);
  endtask

  initial begin
    bit held;
    rst = 1'b1;
    m = empty_ex();
    quiet_wb();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all();
    step();
    #2 rst = 1'b0;

    // Plain capture with rd selected as destination.
    set_id(3, 4, 5, 32'h11, 32'h22, 1, 1, 0);
    step();
    check("cap_wreg", bus.ex_wreg, 32'd5);
    check("cap_opa",  bus.ex_opa,  32'h11);
    check("cap_opb",  bus.ex_opb,  32'h22);
    check("cap_fwd",  {bus.fwd_a, bus.fwd_b}, 32'h0);
    check_all();

    // Asynchronous reset mid-cycle clears everything before any edge.
    #2 rst = 1'b1;
    #1;
    m = empty_ex();
    check("rst_valid", bus.ex_valid, 32'd0);
    check("rst_wreg",  bus.ex_wreg,  32'd0);
    check("rst_stall", bus.stall,    32'd0);
    check_all();
    step();
    #2 rst = 1'b0;

    // EX/MEM wins over MEM/WB, then MEM/WB alone.
    set_id(7, 1, 2, 32'h77, 32'h88, 0, 1, 0);
    step();
    bus.exmem_regwrite = 1; bus.exmem_aw = 7; bus.exmem_alu = 32'hA;
    bus.memwb_regwrite = 1; bus.memwb_aw = 7; bus.memwb_data = 32'hB;
    #1;
    check("pri_fwd_a", bus.fwd_a,  32'd2);
    check("pri_opa",   bus.ex_opa, 32'hA);
    check_all();
    bus.exmem_regwrite = 0;
    #1;
    check("wb_fwd_a", bus.fwd_a,  32'd1);
    check("wb_opa",   bus.ex_opa, 32'hB);
    check_all();
    quiet_wb();

    // Register 0 is never forwarded and never causes a load-use stall.
    set_id(0, 0, 0, 32'h0, 32'h0, 0, 1, 1);
    step();
    bus.exmem_regwrite = 1; bus.exmem_aw = 0; bus.exmem_alu = 32'hDEAD;
    set_id(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    #1;
    check("r0_fwd_b", bus.fwd_b, 32'd0);
    check("r0_stall", bus.stall, 32'd0);
    check_all();
    quiet_wb();

    // Load-use: lw r8, then consumer reading r8.
    set_id(1, 8, 0, 32'h100, 32'h0, 0, 1, 1);
    step();
    set_id(8, 2, 9, 32'h0, 32'h22, 1, 1, 0);
    #1;
    check("lu_stall", bus.stall, 32'd1);
    check_all();
    step();
    check("lu_bubble_valid", bus.ex_valid,    32'd0);
    check("lu_bubble_rw",    bus.ex_regwrite, 32'd0);
    check("lu_stall_off",    bus.stall,       32'd0);
    check_all();
    step();
    bus.memwb_regwrite = 1; bus.memwb_aw = 8; bus.memwb_data = 32'hCAFE;
    #1;
    check("lu_fwd_a", bus.fwd_a,  32'd1);
    check("lu_opa",   bus.ex_opa, 32'hCAFE);
    check("lu_wreg",  bus.ex_wreg, 32'd9);
    check_all();
    quiet_wb();

    // Flush on top of a load-use hazard: bubble, no stall, no recapture.
    set_id(1, 8, 0, 32'h100, 32'h0, 0, 1, 1);
    step();
    set_id(8, 8, 9, 32'h0, 32'h0, 1, 1, 0);
    bus.flush = 1;
    #1;
    check("fl_stall", bus.stall, 32'd0);
    check_all();
    step();
    bus.flush = 0;
    check("fl_valid", bus.ex_valid, 32'd0);
    set_id(3, 3, 6, 32'h33, 32'h33, 1, 1, 0);
    #1;
    check_all();
    step();
    check("fl_next_wreg", bus.ex_wreg, 32'd6);
    check_all();

    // Randomized traffic; front end holds ID while the stage reports a stall.
    held = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) rand_id();
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.exmem_regwrite = 1'($urandom); bus.exmem_aw = 5'($urandom_range(0, 3)); bus.exmem_alu = $urandom;
      bus.memwb_regwrite = 1'($urandom); bus.memwb_aw = 5'($urandom_range(0, 3)); bus.memwb_data = $urandom;
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1;
        m = empty_ex();
        check_all();
        step();
        #1 rst = 1'b0;
        held = 0;
      end else begin
        #1;
        check_all();
        held = load_use(m) && !bus.flush;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 32-bit MIPS datapath. It sits directly downstream of the register file. Each cycle it captures the two read operands (DR1/DR2), the register specifiers, the immediate and the decode control bits into the EX stage. It also detects load-use hazards, which stall the front end and insert a bubble. Combinational forwarding selects the EX operands from EX/MEM or MEM/WB results.

## Interface
- W, 32, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt, id_rd  in  5 each  decode-stage register specifiers (id_rs feeds RA1, id_rt feeds RA2)
- id_dr1, id_dr2  in  W each  register-file read data
- id_imm  in  W  sign-extended immediate
- id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst  in  1 each  decode control
- id_aluop  in  3  ALU operation class
- flush  in  1  branch/jump taken; discard the instruction in ID
- exmem_regwrite  in  1  EX/MEM will write the register file
- exmem_aw  in  5  EX/MEM destination register
- exmem_alu  in  W  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB write enable (RegWrite of the register file)
- memwb_aw  in  5  MEM/WB destination (AW of the register file)
- memwb_data  in  W  MEM/WB write data (WriteData of the register file)
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_wreg  out  5 each  registered specifiers; ex_wreg = id_rd if id_regdst else id_rt
- ex_imm  out  W  registered immediate
- ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc  out  1 each  registered control
- ex_aluop  out  3  registered ALU op
- fwd_a, fwd_b  out  2 each  forwarding selects (00 reg, 10 EX/MEM, 01 MEM/WB)
- ex_opa  out  W  forwarded operand A
- ex_opb  out  W  forwarded operand B, before the ALUSrc mux
- ex_store_data  out  W  equals ex_opb, for stores

## Operation
- Pipeline register: captures all id_* fields on the rising clk edge.
- Load-use hazard, hz = ex_memread & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hz & ~flush.
- Capture priority per edge, highest first:
  - flush: insert bubble.
  - hz: insert bubble.
  - Otherwise: normal capture with ex_valid = 1.
- Bubble: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg all 0. Other fields don't-care; the implementation clears them to 0.
- Registered operands ex_dr1/ex_dr2 are internal and not ports.
- Forwarding A:
  - fwd_a = 10 if exmem_regwrite & exmem_aw != 0 & exmem_aw == ex_rs.
  - Else fwd_a = 01 if memwb_regwrite & memwb_aw != 0 & memwb_aw == ex_rs.
  - Else fwd_a = 00.
  - EX/MEM always wins over MEM/WB.
- Forwarding B: same rules, using ex_rt to form fwd_b.
- ex_opa and ex_opb select ex_dr1/ex_dr2, exmem_alu or memwb_data per fwd_a/fwd_b.
- Register 0 is never forwarded. A reference to $0 yields the registered value, which the register file holds at 0.
- Same-cycle write/read of the register file needs no forwarding here: the register file write path is combinational, so id_dr1/id_dr2 already reflect memwb_data when captured.

## Timing
- Reset (asynchronous, immediate):
  - All ex_* outputs are 0 and ex_valid = 0.
  - fwd_a = fwd_b = 00, so ex_opa = ex_opb = 0.
  - stall = 0 (hz is 0 because ex_valid = 0).
- Latency: id_* appears on ex_* one cycle after the capturing edge.
- stall, fwd_a/b, ex_opa/b and ex_store_data are combinational from the current-cycle state and inputs; none is registered.
- Load-use:
  - stall is high for exactly one cycle.
  - The next edge loads a bubble, so ex_memread drops and stall deasserts.
  - The held ID instruction is recaptured on the following edge.
  - The loaded value then arrives via the MEM/WB forward (fwd = 01).
- flush and hz in the same cycle: bubble, stall = 0.
- Reset asserted mid-stall: state clears immediately; no bubble or recapture is pending after release.
- Back-to-back loads: each dependent consumer stalls independently, one cycle each.

## Test plan
- Reset: assert rst mid-cycle with ex_* nonzero -> all ex_* = 0, ex_valid = 0 and stall = 0 immediately, before any clock edge.
- Plain capture: id_rs=3, id_rt=4, id_rd=5, regdst=1, dr1=0x11, dr2=0x22 -> next cycle ex_wreg=5, ex_opa=0x11, ex_opb=0x22, fwd=00/00.
- EX/MEM over MEM/WB:
  - Setup: ex_rs=7, exmem_aw=7, memwb_aw=7, both regwrite=1, exmem_alu=0xA, memwb_data=0xB.
  - Expected: fwd_a=10, ex_opa=0xA.
  - Then set exmem_regwrite=0 -> fwd_a=01, ex_opa=0xB.
- $0 guard: ex_rt=0, exmem_aw=0, exmem_regwrite=1 -> fwd_b=00.
  - Also: ex_memread=1 with ex_rt=0 -> stall=0.
- Load-use:
  - lw into r8 in EX, ID reads rs=8 -> stall=1 for one cycle.
  - Next cycle: ex_valid=0, ex_regwrite=0.
  - Following cycle: consumer in EX, fwd_a=01 with memwb_aw=8.
- Flush vs hazard: hz condition plus flush=1 -> stall=0, and the next edge gives ex_valid=0 with no recapture.
